// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares the single dev_ram port between two requesters:
//     r0 = program loader, r1 = control unit.
//   Each grant issues one transaction. Arbitration is combinational in the request
//   cycle. A requester can lock the bus across several grants. Read data is routed
//   back to the requester that issued the read, using a fixed-latency tag pipeline.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   rN_req/op/size/addr/wdata   requester N transaction (op: 0 read, 1 write)
//   rN_lock                     keep ownership after this grant
//   rN_gnt                      request accepted this cycle
//   rN_rvalid/rN_rdata          read return for requester N
//   ram_op/size/addr/wdata      forwarded transaction (op: 0 NOP, 1 READ, 2 WRITE)
//   ram_rdata                   dev_ram read data, READ_LAT cycles after READ issue

// Per-requester read-return qualifier. Both requesters always see ram_rdata;
// only the valid strobe is steered by the owner tag.
module ram_arbiter_ret #(
  parameter int DATA_W = 64,
  parameter int ID     = 0
) (
  input  logic              rst,
  input  logic              tag_vld,
  input  logic              tag_own,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata
);
  // Masking with rst keeps a read that was in flight from surfacing while
  // reset is asserted. The pipeline itself is cleared on the same edge.
  assign rvalid = tag_vld && !rst && (tag_own == 1'(ID));
  assign rdata  = ram_rdata;
endmodule

module ram_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int READ_LAT = 1,
  parameter int ARB_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_op,
  input  logic [1:0]        r0_size,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic              r0_lock,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_op,
  input  logic [1:0]        r1_size,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  input  logic              r1_lock,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [1:0]        ram_op,
  output logic [1:0]        ram_size,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int NREQ = 2;
  localparam logic [1:0] RAM_NOP   = 2'd0;
  localparam logic [1:0] RAM_READ  = 2'd1;
  localparam logic [1:0] RAM_WRITE = 2'd2;

  typedef struct packed {
    logic              req;
    logic              op;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              lock;
  } req_t;

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  req_t [NREQ-1:0] rq;
  req_t            g;
  state_t          state, state_nxt;
  logic            rr_ptr;   // requester favoured on the next contended IDLE cycle
  logic [NREQ-1:0] gnt;
  logic            sel;

  assign rq[0] = {r0_req, r0_op, r0_size, r0_addr, r0_wdata, r0_lock};
  assign rq[1] = {r1_req, r1_op, r1_size, r1_addr, r1_wdata, r1_lock};

  // Grant and next-state logic. Nothing is granted while rst is high.
  always_comb begin
    gnt       = '0;
    state_nxt = state;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (rq[0].req && rq[1].req)
            gnt = ((ARB_MODE != 0) || !rr_ptr) ? 2'b01 : 2'b10;
          else
            gnt = {rq[1].req, rq[0].req};
          if (gnt[0] && rq[0].lock)      state_nxt = LOCK0;
          else if (gnt[1] && rq[1].lock) state_nxt = LOCK1;
        end
        // The owner may still issue one last transaction on the cycle it drops
        // lock. The other side only competes again from the next cycle.
        LOCK0: begin
          gnt[0] = rq[0].req;
          if (!rq[0].lock) state_nxt = IDLE;
        end
        LOCK1: begin
          gnt[1] = rq[1].req;
          if (!rq[1].lock) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign sel    = gnt[1];
  assign g      = rq[sel];
  assign r0_gnt = gnt[0];
  assign r1_gnt = gnt[1];

  assign ram_op    = (|gnt) ? (g.op ? RAM_WRITE : RAM_READ) : RAM_NOP;
  assign ram_size  = (|gnt) ? g.size  : '0;
  assign ram_addr  = (|gnt) ? g.addr  : '0;
  assign ram_wdata = (|gnt) ? g.wdata : '0;

  // Read tag pipeline. Stage 0 is the issue cycle and is combinational.
  // Stage READ_LAT lines up with ram_rdata.
  logic                issue_vld;
  logic [READ_LAT:0]   vld_pipe, own_pipe;
  logic [READ_LAT:1]   vld_q, own_q;

  assign issue_vld = (|gnt) && !g.op;
  assign vld_pipe  = {vld_q, issue_vld};
  assign own_pipe  = {own_q, sel};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= 1'b0;
      vld_q  <= '0;
      own_q  <= '0;
    end else begin
      state <= state_nxt;
      if (|gnt) rr_ptr <= ~sel;
      vld_q <= vld_pipe[READ_LAT-1:0];
      own_q <= own_pipe[READ_LAT-1:0];
    end
  end

  logic [NREQ-1:0]             rvalid;
  logic [NREQ-1:0][DATA_W-1:0] rdata;

  for (genvar n = 0; n < NREQ; n++) begin : g_ret
    ram_arbiter_ret #(.DATA_W(DATA_W), .ID(n)) u_ret (
      .rst       (rst),
      .tag_vld   (vld_pipe[READ_LAT]),
      .tag_own   (own_pipe[READ_LAT]),
      .ram_rdata (ram_rdata),
      .rvalid    (rvalid[n]),
      .rdata     (rdata[n])
    );
  end

  assign r0_rvalid = rvalid[0];
  assign r1_rvalid = rvalid[1];
  assign r0_rdata  = rdata[0];
  assign r1_rdata  = rdata[1];

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          r0_req, r0_op, r0_lock, r1_req, r1_op, r1_lock;
  logic [1:0]    r0_size, r1_size;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata, ram_rdata;

  logic          r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [DW-1:0] r0_rdata, r1_rdata, ram_wdata;
  logic [1:0]    ram_op, ram_size;
  logic [AW-1:0] ram_addr;

  logic          f0_gnt, f0_rvalid, f1_gnt, f1_rvalid;
  logic [DW-1:0] f0_rdata, f1_rdata, f_wdata;
  logic [1:0]    f_op, f_size;
  logic [AW-1:0] f_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1), .ARB_MODE(0)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_op(r0_op), .r0_size(r0_size), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_lock(r0_lock), .r0_gnt(r0_gnt),
    .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_op(r1_op), .r1_size(r1_size), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_lock(r1_lock), .r1_gnt(r1_gnt),
    .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .ram_op(ram_op), .ram_size(ram_size), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1), .ARB_MODE(1)) dut_fp (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_op(r0_op), .r0_size(r0_size), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_lock(r0_lock), .r0_gnt(f0_gnt),
    .r0_rvalid(f0_rvalid), .r0_rdata(f0_rdata),
    .r1_req(r1_req), .r1_op(r1_op), .r1_size(r1_size), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_lock(r1_lock), .r1_gnt(f1_gnt),
    .r1_rvalid(f1_rvalid), .r1_rdata(f1_rdata),
    .ram_op(f_op), .ram_size(f_size), .ram_addr(f_addr),
    .ram_wdata(f_wdata), .ram_rdata(ram_rdata)
  );

  // Inputs are driven 1 time unit after posedge and outputs sampled 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    r0_req = 0; r0_op = 0; r0_size = 0; r0_addr = '0; r0_wdata = '0; r0_lock = 0;
    r1_req = 0; r1_op = 0; r1_size = 0; r1_addr = '0; r1_wdata = '0; r1_lock = 0;
    ram_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; r0_req = 1; r1_req = 1; ram_rdata = 64'h1234;
    for (int c = 0; c < 2; c++) begin
      #2;
      checks++;
      if ({r0_gnt, r1_gnt} !== 2'b00) begin
        failures++; $display("FAIL reset_gnt cyc%0d: got %b want 00", c, {r0_gnt, r1_gnt});
      end
      checks++;
      if (ram_op !== 2'd0) begin
        failures++; $display("FAIL reset_ram_op cyc%0d: got %0d want 0", c, ram_op);
      end
      checks++;
      if ({r0_rvalid, r1_rvalid} !== 2'b00) begin
        failures++; $display("FAIL reset_rvalid cyc%0d: got %b want 00", c, {r0_rvalid, r1_rvalid});
      end
      tick();
    end
    rst = 0;
    idle_inputs();
  endtask

  task automatic test_single_read();
    do_reset();
    r0_req = 1; r0_op = 0; r0_size = 2'd3; r0_addr = 32'h10;
    #2;
    checks++;
    if ({r0_gnt, r1_gnt, ram_op, ram_addr} !== {1'b1, 1'b0, 2'd1, 32'h10}) begin
      failures++;
      $display("FAIL single_read_issue: got gnt=%b%b op=%0d addr=%h want gnt=10 op=1 addr=10",
               r0_gnt, r1_gnt, ram_op, ram_addr);
    end
    tick();
    r0_req = 0; ram_rdata = 64'hDEAD;
    #2;
    checks++;
    if ({r0_rvalid, r1_rvalid, r0_rdata} !== {1'b1, 1'b0, 64'hDEAD}) begin
      failures++;
      $display("FAIL single_read_return: got rv=%b%b rdata=%h want rv=10 rdata=dead",
               r0_rvalid, r1_rvalid, r0_rdata);
    end
    checks++;
    if (ram_op !== 2'd0) begin
      failures++; $display("FAIL single_read_nop_after: got %0d want 0", ram_op);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_write();
    do_reset();
    r1_req = 1; r1_op = 1; r1_size = 2'd3; r1_addr = 32'h20; r1_wdata = 64'h55;
    #2;
    checks++;
    if ({r1_gnt, r0_gnt, ram_op, ram_size, ram_addr, ram_wdata} !==
        {1'b1, 1'b0, 2'd2, 2'd3, 32'h20, 64'h55}) begin
      failures++;
      $display("FAIL write_issue: got gnt1=%b op=%0d size=%0d addr=%h wdata=%h want 1 2 3 20 55",
               r1_gnt, ram_op, ram_size, ram_addr, ram_wdata);
    end
    tick();
    r1_req = 0; ram_rdata = 64'h77;
    #2;
    checks++;
    if ({r0_rvalid, r1_rvalid} !== 2'b00) begin
      failures++; $display("FAIL write_no_rvalid: got %b%b want 00", r0_rvalid, r1_rvalid);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_arbitration();
    logic [1:0] exp_rr;
    do_reset();
    r0_req = 1; r0_op = 1; r1_req = 1; r1_op = 1;
    for (int c = 0; c < 6; c++) begin
      exp_rr = (c % 2 == 0) ? 2'b01 : 2'b10;
      #2;
      checks++;
      if ({r1_gnt, r0_gnt} !== exp_rr) begin
        failures++; $display("FAIL rr_gnt cyc%0d: got %b want %b", c, {r1_gnt, r0_gnt}, exp_rr);
      end
      checks++;
      if ({f1_gnt, f0_gnt} !== 2'b01) begin
        failures++; $display("FAIL fixed_gnt cyc%0d: got %b want 01", c, {f1_gnt, f0_gnt});
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_lock();
    do_reset();
    r0_req = 1; r0_op = 1; r0_lock = 1; r1_req = 1; r1_op = 1;
    for (int c = 0; c < 4; c++) begin
      #2;
      checks++;
      if ({r1_gnt, r0_gnt} !== 2'b01) begin
        failures++; $display("FAIL lock_hold cyc%0d: got %b want 01", c, {r1_gnt, r0_gnt});
      end
      tick();
    end
    r0_lock = 0;
    #2;
    checks++;
    if ({r1_gnt, r0_gnt} !== 2'b01) begin
      failures++; $display("FAIL lock_release_cycle: got %b want 01", {r1_gnt, r0_gnt});
    end
    tick();
    #2;
    checks++;
    if ({r1_gnt, r0_gnt} !== 2'b10) begin
      failures++; $display("FAIL lock_after_release: got %b want 10", {r1_gnt, r0_gnt});
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_lock_idle_owner();
    do_reset();
    r0_req = 1; r0_op = 1; r0_lock = 1;
    tick();
    r0_req = 0; r1_req = 1; r1_op = 1;
    #2;
    checks++;
    if ({r1_gnt, r0_gnt, ram_op} !== {2'b00, 2'd0}) begin
      failures++; $display("FAIL lock_idle_owner: got gnt=%b op=%0d want gnt=00 op=0",
                           {r1_gnt, r0_gnt}, ram_op);
    end
    tick();
    r0_lock = 0;
    #2;
    checks++;
    if ({r1_gnt, r0_gnt} !== 2'b00) begin
      failures++; $display("FAIL lock_drop_no_other: got %b want 00", {r1_gnt, r0_gnt});
    end
    tick();
    #2;
    checks++;
    if ({r1_gnt, r0_gnt} !== 2'b10) begin
      failures++; $display("FAIL lock_drop_then_r1: got %b want 10", {r1_gnt, r0_gnt});
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_interleaved_reads();
    do_reset();
    r0_req = 1; r0_op = 0; r0_addr = 32'h0;
    #2;
    checks++;
    if ({r0_gnt, ram_op, ram_addr} !== {1'b1, 2'd1, 32'h0}) begin
      failures++; $display("FAIL ilv_issue0: got gnt0=%b op=%0d addr=%h want 1 1 0", r0_gnt, ram_op, ram_addr);
    end
    tick();
    r0_req = 0; r1_req = 1; r1_op = 0; r1_addr = 32'h8; ram_rdata = 64'hA0;
    #2;
    checks++;
    if ({r1_gnt, ram_op, ram_addr} !== {1'b1, 2'd1, 32'h8}) begin
      failures++; $display("FAIL ilv_issue1: got gnt1=%b op=%0d addr=%h want 1 1 8", r1_gnt, ram_op, ram_addr);
    end
    checks++;
    if ({r0_rvalid, r1_rvalid, r0_rdata} !== {2'b10, 64'hA0}) begin
      failures++; $display("FAIL ilv_ret0: got rv=%b%b rdata=%h want rv=10 rdata=a0", r0_rvalid, r1_rvalid, r0_rdata);
    end
    tick();
    r1_req = 0; ram_rdata = 64'hB8;
    #2;
    checks++;
    if ({r0_rvalid, r1_rvalid, r1_rdata} !== {2'b01, 64'hB8}) begin
      failures++; $display("FAIL ilv_ret1: got rv=%b%b rdata=%h want rv=01 rdata=b8", r0_rvalid, r1_rvalid, r1_rdata);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_d;
    do_reset();
    r0_req = 1; r0_op = 0;
    for (int c = 0; c < 4; c++) begin
      r0_addr = 32'(c * 8);
      ram_rdata = 64'(256 + c);
      if (c == 3) r0_req = 0;
      #2;
      checks++;
      if (r0_gnt !== (c < 3)) begin
        failures++; $display("FAIL b2b_gnt cyc%0d: got %b want %b", c, r0_gnt, (c < 3));
      end
      exp_d = 64'(256 + c);
      checks++;
      if (r0_rvalid !== (c > 0) || (c > 0 && r0_rdata !== exp_d)) begin
        failures++; $display("FAIL b2b_ret cyc%0d: got rv=%b rdata=%h want rv=%b rdata=%h",
                             c, r0_rvalid, r0_rdata, (c > 0), exp_d);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset_inflight();
    do_reset();
    r0_req = 1; r0_op = 0; r0_addr = 32'h40;
    tick();
    r0_req = 0; rst = 1; ram_rdata = 64'hBEEF;
    #2;
    checks++;
    if ({r0_rvalid, r1_rvalid, ram_op} !== {2'b00, 2'd0}) begin
      failures++; $display("FAIL inflight_rst: got rv=%b%b op=%0d want rv=00 op=0", r0_rvalid, r1_rvalid, ram_op);
    end
    tick();
    rst = 0;
    #2;
    checks++;
    if ({r0_rvalid, r1_rvalid} !== 2'b00) begin
      failures++; $display("FAIL inflight_after_rst: got %b%b want 00", r0_rvalid, r1_rvalid);
    end
    tick();
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    tick();
    test_reset();
    test_single_read();
    test_write();
    test_arbitration();
    test_lock();
    test_lock_idle_owner();
    test_interleaved_reads();
    test_back_to_back();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
